joy_db15_tx: RTL and testbench
==============================

JOY_DB15_TX -- requirements
Module: joy_db15_tx

Interface
REQ-001 Parameter: PLAYER_BITS, default 12, button bits sent per player; frame length = 2*PLAYER_BITS.
REQ-002 clk  input  1  system clock, 40-50 MHz; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 joystick1  input  PLAYER_BITS  player 1 buttons, active-high, bit0=R, 1=L, 2=D, 3=U, 4.. fire/start/coin.
REQ-005 joystick2  input  PLAYER_BITS  player 2 buttons, same layout.
REQ-006 joy_clk_in  input  1  shift clock from the DB15 reader, asynchronous to clk.
REQ-007 joy_load_in  input  1  parallel load from the reader, active-low, asynchronous to clk.
REQ-008 joy_data_out  output  1  serial button data, active-low (0 = pressed).
REQ-009 frame_done  output  1  one-cycle pulse when the last frame bit has been shifted out.
REQ-010 frame_cnt  output  8  completed-frame counter, wraps 255->0.
REQ-011 err_short  output  1  sticky; load arrived before frame complete.
REQ-012 err_over  output  1  sticky; shift clock received after frame complete.

Function
REQ-013 joy_clk_in and joy_load_in each SHALL pass a 2-flop synchronizer; edge detection uses the synchronized value plus one delay flop.
REQ-014 Shift register sr SHALL be 2*PLAYER_BITS wide: {joystick2, joystick1}, with joystick1 bit0 sent first.
REQ-015 joy_data_out SHALL be registered and equal ~sr[0].
REQ-016 States: IDLE, LOAD, SHIFT, DONE; bit counter bcnt sized ceil(log2(2*PLAYER_BITS+1)).
REQ-017 While synchronized load is low: state LOAD, sr reloaded every cycle from the inputs, bcnt=0. Rising shift-clock edges are ignored (load has priority).
REQ-018 Synchronized load rising edge: LOAD->SHIFT; sr holds the last loaded value.
REQ-019 In SHIFT, each synchronized clk rising edge SHALL shift sr right with 0 filled at the MSB, so the output idles high, and increment bcnt.
REQ-020 When bcnt reaches 2*PLAYER_BITS-1 and a further rising edge occurs, SHIFT->DONE; frame_done pulses one cycle and frame_cnt increments.
REQ-021 In DONE, rising shift-clock edges SHALL keep joy_data_out=1, set err_over, and leave bcnt saturated.
REQ-022 Load falling edge while in SHIFT with bcnt>0 SHALL set err_short; the block then enters LOAD normally. frame_done does not pulse and frame_cnt does not change.
REQ-023 joy_data_out SHALL reflect a shift or load no later than 4 clk cycles after the pin edge. The reader's clk/load high and low phases are each >=3 clk cycles.
REQ-024 IDLE is entered only from reset. Load low or a rising shift-clock edge leaves IDLE: load low goes to LOAD; a shift edge goes to DONE with err_over set.

Reset
REQ-025 While reset_n is low: state=IDLE, sr=0, bcnt=0, joy_data_out=1, frame_done=0, frame_cnt=0, err_short=0, err_over=0, synchronizer flops=1 (lines idle high).
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately with no frame_done pulse. Release SHALL take effect on the first clk edge with reset_n high.

Configuration
REQ-027 Macro JOY_DB15_TX_STATS_EN: when defined, frame_cnt, err_short and err_over are implemented as specified.
REQ-028 When JOY_DB15_TX_STATS_EN is undefined: frame_cnt, err_short and err_over are tied to 0 with no flops; frame_done and serial behaviour are unchanged.

Verification
REQ-029 PLAYER_BITS=12, joystick1=12'h001, joystick2=12'h800, 24 clean clock pulses after load -> serial bits 0,1x22,0; frame_done pulses once; frame_cnt=1.
REQ-030 Load held low for 20 cycles while joystick1 changes 0->12'h00F -> first bit after load release reflects 12'h00F; clk pulses during load leave bcnt=0.
REQ-031 26 clock pulses after load -> bits 25 and 26 read 1; err_over=1; frame_cnt=1.
REQ-032 Load reasserted after 10 pulses -> err_short=1, no frame_done; the next full frame completes with frame_cnt=1.
REQ-033 reset_n low at pulse 7, then released -> joy_data_out=1, all counters 0; the next load/24-pulse frame is correct.
REQ-034 Build without JOY_DB15_TX_STATS_EN, rerun REQ-031 -> err_over=0, frame_cnt=0; serial data is identical to the stats-enabled build.

Source files
------------

// File: rtl/joy_db15_tx_if.sv
// joy_db15_tx_if: pin-level and status bundle between a DB15 joystick serializer and its host.
// master = host/reader side, slave = the serializer.
interface joy_db15_tx_if #(
  parameter int PLAYER_BITS = 12
) ();
  logic [PLAYER_BITS-1:0] joystick1;
  logic [PLAYER_BITS-1:0] joystick2;
  logic                   joy_clk_in;
  logic                   joy_load_in;
  logic                   joy_data_out;
  logic                   frame_done;
  logic [7:0]             frame_cnt;
  logic                   err_short;
  logic                   err_over;

  modport master (
    output joystick1, joystick2, joy_clk_in, joy_load_in,
    input  joy_data_out, frame_done, frame_cnt, err_short, err_over
  );

  modport slave (
    input  joystick1, joystick2, joy_clk_in, joy_load_in,
    output joy_data_out, frame_done, frame_cnt, err_short, err_over
  );
endinterface

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: serializes two players' buttons onto a DB15 reader's clk/load pins (active-low data).
// Optional statistics (frame_cnt, err_short, err_over) are built only with JOY_DB15_TX_STATS_EN.
module joy_db15_tx #(
  parameter int PLAYER_BITS = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  joy_db15_tx_if.slave bus
);
  localparam int FRAME = 2 * PLAYER_BITS;
  localparam int BW    = $clog2(FRAME + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);
  localparam logic [BW-1:0] FULL_CNT = BW'(FRAME);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // [0],[1] form the synchronizer, [2] is the edge-detect delay flop
  logic [2:0]       clk_sync_q;
  logic [2:0]       ld_sync_q;
  state_e           state_q, state_d;
  logic [FRAME-1:0] sr_q, sr_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             data_out_q;
  logic             frame_done_q, frame_done_d;
  logic             clk_rise_s;
  logic             load_low_s;
  logic             load_fall_s;

  assign clk_rise_s  = clk_sync_q[1] & ~clk_sync_q[2];
  assign load_low_s  = ~ld_sync_q[1];
  assign load_fall_s = ~ld_sync_q[1] & ld_sync_q[2];

  // Synchronizers for the reader's asynchronous pins, idling high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 3'b111;
      ld_sync_q  <= 3'b111;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], bus.joy_clk_in};
      ld_sync_q  <= {ld_sync_q[1:0], bus.joy_load_in};
    end
  end

  // State, shift register, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sr_q         <= {FRAME{1'b0}};
      bcnt_q       <= {BW{1'b0}};
      data_out_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bcnt_q       <= bcnt_d;
      data_out_q   <= ~sr_d[0];
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic; a low load overrides everything, including shift edges
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bcnt_d       = bcnt_q;
    frame_done_d = 1'b0;
    if (load_low_s) begin
      state_d = LOAD;
      sr_d    = {bus.joystick2, bus.joystick1};
      bcnt_d  = {BW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (clk_rise_s) begin
            state_d = DONE;
            bcnt_d  = FULL_CNT;
          end else begin
            state_d = IDLE;
          end
        end
        LOAD: begin
          state_d = SHIFT;
        end
        SHIFT: begin
          if (clk_rise_s) begin
            sr_d   = {1'b0, sr_q[FRAME-1:1]};
            bcnt_d = bcnt_q + BW'(1);
            if (bcnt_q == LAST_BIT) begin
              state_d      = DONE;
              frame_done_d = 1'b1;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            state_d = SHIFT;
          end
        end
        DONE: begin
          if (clk_rise_s) begin
            sr_d   = {FRAME{1'b0}};
            bcnt_d = FULL_CNT;
          end else begin
            bcnt_d = bcnt_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.joy_data_out = data_out_q;
  assign bus.frame_done   = frame_done_q;

`ifdef JOY_DB15_TX_STATS_EN
  logic [7:0] frame_cnt_q;
  logic       err_short_q;
  logic       err_over_q;
  logic       err_short_set_s;
  logic       err_over_set_s;

  // Error conditions: frame cut short by a new load, or shifting past the end
  always_comb begin
    err_short_set_s = load_fall_s & (state_q == SHIFT) & (bcnt_q != {BW{1'b0}});
    err_over_set_s  = clk_rise_s & ~load_low_s & ((state_q == DONE) | (state_q == IDLE));
  end

  // Sticky error flags and wrapping frame counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= 8'd0;
      err_short_q <= 1'b0;
      err_over_q  <= 1'b0;
    end else begin
      if (frame_done_d) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end else begin
        frame_cnt_q <= frame_cnt_q;
      end
      err_short_q <= err_short_q | err_short_set_s;
      err_over_q  <= err_over_q | err_over_set_s;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_short = err_short_q;
  assign bus.err_over  = err_over_q;
`else
  assign bus.frame_cnt = 8'd0;
  assign bus.err_short = 1'b0;
  assign bus.err_over  = 1'b0;
`endif
endmodule

// File: tb/tb_joy_db15_tx.sv
// tb_joy_db15_tx: directed table of frames plus hand-written corner sequences for joy_db15_tx.
module tb_joy_db15_tx;
`ifdef JOY_DB15_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [11:0] j1;
    logic [11:0] j2;
    logic [23:0] exp_stream; // bit i = joy_data_out after i pulses
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   fd_cnt = 0;

  joy_db15_tx_if #(.PLAYER_BITS(12)) bus ();

  joy_db15_tx #(.PLAYER_BITS(12)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(2);
  endtask

  task automatic pulse();
    bus.joy_clk_in = 1'b0;
    wait_cyc(4);
    bus.joy_clk_in = 1'b1;
    wait_cyc(4);
  endtask

  task automatic do_load(input int low_cyc);
    bus.joy_load_in = 1'b0;
    wait_cyc(low_cyc);
    bus.joy_load_in = 1'b1;
    wait_cyc(4);
  endtask

  task automatic run_frame(input int n, output logic [31:0] bits);
    bits = 32'd0;
    bits[0] = bus.joy_data_out;
    for (int i = 1; i <= n; i++) begin
      pulse();
      bits[i] = bus.joy_data_out;
    end
  endtask

  function automatic logic [31:0] st(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  vec_t        vecs[6];
  logic [31:0] bits;
  int          fd0;

  initial begin
    vecs[0] = '{j1: 12'h001, j2: 12'h800, exp_stream: 24'h7FFFFE};
    vecs[1] = '{j1: 12'h00F, j2: 12'h000, exp_stream: 24'hFFFFF0};
    vecs[2] = '{j1: 12'hABC, j2: 12'h123, exp_stream: 24'hEDC543};
    vecs[3] = '{j1: 12'hFFF, j2: 12'hFFF, exp_stream: 24'h000000};
    vecs[4] = '{j1: 12'h000, j2: 12'h000, exp_stream: 24'hFFFFFF};
    vecs[5] = '{j1: 12'h5A5, j2: 12'hC3C, exp_stream: 24'h3C3A5A};

    bus.joystick1   = 12'h000;
    bus.joystick2   = 12'h000;
    bus.joy_clk_in  = 1'b1;
    bus.joy_load_in = 1'b1;

    // Reset values while reset_n is low
    wait_cyc(3);
    chk("rst_data", bus.joy_data_out, 32'd1);
    chk("rst_fdone", bus.frame_done, 32'd0);
    chk("rst_fcnt", bus.frame_cnt, 32'd0);
    chk("rst_eshort", bus.err_short, 32'd0);
    chk("rst_eover", bus.err_over, 32'd0);
    reset_n = 1'b1;
    wait_cyc(2);
    chk("idle_data", bus.joy_data_out, 32'd1);

    // Table of clean 24-pulse frames
    for (int k = 0; k < 6; k++) begin
      bus.joystick1 = vecs[k].j1;
      bus.joystick2 = vecs[k].j2;
      do_load(6);
      fd0 = fd_cnt;
      run_frame(24, bits);
      chk($sformatf("tbl%0d_stream", k), bits[24:0], {7'd0, 1'b1, vecs[k].exp_stream});
      chk($sformatf("tbl%0d_fdone", k), fd_cnt - fd0, 32'd1);
      chk($sformatf("tbl%0d_fcnt", k), bus.frame_cnt, st(k + 1));
    end
    chk("tbl_eshort", bus.err_short, 32'd0);
    chk("tbl_eover", bus.err_over, 32'd0);

    // Long load with changing buttons and shift pulses during load
    do_reset();
    bus.joystick1 = 12'h000;
    bus.joystick2 = 12'h000;
    bus.joy_load_in = 1'b0;
    wait_cyc(4);
    pulse();
    bus.joystick1 = 12'h00F;
    wait_cyc(8);
    bus.joy_load_in = 1'b1;
    wait_cyc(4);
    chk("ld_first_bit", bus.joy_data_out, 32'd0);
    fd0 = fd_cnt;
    bits = 32'd0;
    bits[0] = bus.joy_data_out;
    for (int i = 1; i <= 23; i++) begin
      pulse();
      bits[i] = bus.joy_data_out;
    end
    chk("ld_fdone_23", fd_cnt - fd0, 32'd0);
    pulse();
    bits[24] = bus.joy_data_out;
    chk("ld_fdone_24", fd_cnt - fd0, 32'd1);
    chk("ld_stream", bits[24:0], 32'h01FFFFF0);

    // Over-length frame: 26 pulses
    do_reset();
    bus.joystick1 = 12'h001;
    bus.joystick2 = 12'h800;
    do_load(6);
    fd0 = fd_cnt;
    run_frame(26, bits);
    chk("ov_stream", bits[23:0], 32'h007FFFFE);
    chk("ov_tail", bits[26:24], 32'd7);
    chk("ov_eover", bus.err_over, st(1));
    chk("ov_fcnt", bus.frame_cnt, st(1));
    chk("ov_fdone", fd_cnt - fd0, 32'd1);

    // Load reasserted after 10 pulses
    do_reset();
    do_load(6);
    fd0 = fd_cnt;
    run_frame(10, bits);
    do_load(6);
    chk("sh_eshort", bus.err_short, st(1));
    chk("sh_fdone", fd_cnt - fd0, 32'd0);
    chk("sh_fcnt0", bus.frame_cnt, st(0));
    run_frame(24, bits);
    chk("sh_stream", bits[24:0], 32'h017FFFFE);
    chk("sh_fcnt1", bus.frame_cnt, st(1));

    // Reset asserted mid-frame at pulse 7
    do_reset();
    do_load(6);
    fd0 = fd_cnt;
    run_frame(6, bits);
    bus.joy_clk_in = 1'b0;
    wait_cyc(2);
    #3 reset_n = 1'b0;
    wait_cyc(2);
    chk("mr_data", bus.joy_data_out, 32'd1);
    chk("mr_fdone_pin", bus.frame_done, 32'd0);
    chk("mr_fcnt", bus.frame_cnt, 32'd0);
    bus.joy_clk_in = 1'b1;
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(4);
    chk("mr_idle_data", bus.joy_data_out, 32'd1);
    chk("mr_no_fdone", fd_cnt - fd0, 32'd0);
    do_load(6);
    run_frame(24, bits);
    chk("mr_stream", bits[24:0], 32'h017FFFFE);
    chk("mr_fcnt1", bus.frame_cnt, st(1));

    // Shift edge straight out of IDLE
    do_reset();
    fd0 = fd_cnt;
    pulse();
    chk("id_eover", bus.err_over, st(1));
    chk("id_data", bus.joy_data_out, 32'd1);
    chk("id_fdone", fd_cnt - fd0, 32'd0);
    do_load(6);
    run_frame(24, bits);
    chk("id_stream", bits[24:0], 32'h017FFFFE);
    chk("id_fcnt", bus.frame_cnt, st(1));

    // Reload with no bits shifted is not a short frame
    do_reset();
    do_load(6);
    do_load(6);
    chk("z_eshort", bus.err_short, 32'd0);
    run_frame(24, bits);
    chk("z_stream", bits[24:0], 32'h017FFFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
